alu8_mul_seq: RTL and testbench
===============================

// Module: alu8_mul_seq
// PURPOSE
//  Multi-cycle controller that sequences the shared 8-bit ALU (alu8) to perform an
//  unsigned 8x8->16 shift-and-add multiply. It drives the ALU's A, B, CI and OP inputs
//  and consumes F and CO. Its operands come from the core's extended-op path.
//  While it owns the ALU (alu_own=1), the core's ALU input mux selects this block.
// PARAMETERS
//  OP_ADD        7'b0001001  alu8 OP for A plus B (shift bits 0, M=0, S=1001)
//  OP_SHR        7'b0100000  alu8 OP for shift right: F={CI,A[7:1]}, CO=A[0]
//  ADD_CI        1'b0        CI value meaning "no carry in" for OP_ADD
//  ADD_CO_CARRY  1'b1        alu_co level that means "carry out" after OP_ADD
// PORTS
//  clk       in   1   clock; all state updates on rising edge
//  reset     in   1   synchronous, active-high reset
//  start     in   1   request; sampled only in IDLE
//  a_in      in   8   multiplicand; captured when start is accepted
//  b_in      in   8   multiplier; captured when start is accepted
//  busy      out  1   high in ADD, SHIFT and DONE
//  done      out  1   one-cycle pulse; high while in DONE
//  product   out  16  result; valid from DONE until the next accepted start
//  alu_own   out  1   high in ADD and SHIFT; the block drives the ALU
//  alu_a     out  8   to alu8 A
//  alu_b     out  8   to alu8 B
//  alu_ci    out  1   to alu8 CI
//  alu_op    out  7   to alu8 OP
//  alu_f     in   8   from alu8 F
//  alu_co    in   1   from alu8 CO
// BEHAVIOUR
//  Internal registers: M[7:0] (multiplicand), Q[7:0] (multiplier/low product),
//   ACC[7:0] (high product), C (carry), cnt[2:0], and the state.
//  States: IDLE, ADD, SHIFT, DONE. All outputs are decoded from registered state.
//  Reset: state=IDLE; M, Q, ACC, C, cnt and product = 0; busy=done=alu_own=0.
//  Reset wins over every other event; reset during ADD/SHIFT/DONE aborts to IDLE.
//  When alu_own=0: alu_a=alu_b=0, alu_ci=0, alu_op=0.
//  IDLE: if start: M<=a_in, Q<=b_in, ACC<=0, C<=0, cnt<=0, go to ADD; else stay.
//   product holds its value.
//  ADD: drive alu_a=ACC, alu_b=M, alu_op=OP_ADD, alu_ci=ADD_CI.
//   If Q[0]=1: ACC<=alu_f and C<=(alu_co==ADD_CO_CARRY).
//   If Q[0]=0: ACC is unchanged and C<=0. Always go to SHIFT.
//  SHIFT: drive alu_a=ACC, alu_b=0, alu_op=OP_SHR, alu_ci=C.
//   ACC<=alu_f; Q<={alu_co,Q[7:1]}; cnt<=cnt+1.
//   If cnt==7, go to DONE and product<={alu_f, alu_co, Q[7:1]}; else go to ADD.
//  DONE: done=1, busy=1; go to IDLE next cycle.
//  Latency: start is accepted at edge t (IDLE). ADD/SHIFT occupy 16 cycles (t+1..t+16).
//   done is high in cycle t+17. busy is high t+1..t+17.
//   A new start can be accepted at edge t+18 (back-to-back gap of 1 IDLE cycle).
//  start while busy=1 is ignored, with no queuing. start held high in IDLE re-triggers.
//  cnt wraps 7->0 on the final SHIFT. It is unused outside ADD/SHIFT.
//  Width rule: the ACC+M sum is 9 bits, with the carry held in C.
//   C always enters bit 7 on the following shift, so there is no overflow.
//   Maximum result 0xFF*0xFF=0xFE01.
// TESTING
//  Harness: instantiate with a real alu8 wired to the alu_* ports.
//  T1 reset, then a_in=0x0D, b_in=0x0B, start pulse -> done only in cycle t+17,
//   product=0x008F.
//  T2 a_in=0xFF, b_in=0xFF -> product=0xFE01; checks the carry path through C.
//  T3 a_in=0x00, b_in=0xA5 and a_in=0x5A, b_in=0x00 -> product=0x0000 both times.
//  T4 start again at t+5 with different operands -> ignored; result of first op is correct.
//  T5 reset asserted at t+9 -> next cycle IDLE, product=0, busy=done=alu_own=0;
//   a new op then completes correctly.
//  T6 start held high across two ops (0x12*0x34 then new operands) -> second accepted
//   at t+18; products 0x03A8 and the second value; alu_* outputs are 0 while not owned.

Source files
------------

// File: rtl/alu8_mul_seq.sv
// Sequencer that borrows the shared alu8 to form an unsigned 8x8->16 product
// by shift-and-add, one ADD and one SHIFT step per multiplier bit.
module alu8_mul_seq #(
  parameter logic [6:0] OP_ADD       = 7'b0001001,
  parameter logic [6:0] OP_SHR       = 7'b0100000,
  parameter logic       ADD_CI       = 1'b0,
  parameter logic       ADD_CO_CARRY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        alu_own,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_ci,
  output logic [6:0]  alu_op,
  input  logic [7:0]  alu_f,
  input  logic        alu_co
);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  m_q, m_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  acc_q, acc_d;
  logic        c_q, c_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // ALU drive depends only on registered state, so the path out to alu8 and
  // back through alu_f never forms a combinational loop inside this block.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_ci = 1'b0;
    alu_op = '0;
    case (state_q)
      ADD: begin
        alu_a  = acc_q;
        alu_b  = m_q;
        alu_op = OP_ADD;
        alu_ci = ADD_CI;
      end
      SHIFT: begin
        alu_a  = acc_q;
        alu_op = OP_SHR;
        alu_ci = c_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a_in;
          q_d     = b_in;
          acc_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        if (q_q[0]) begin
          acc_d = alu_f;
          c_d   = (alu_co == ADD_CO_CARRY);
        end else begin
          c_d = 1'b0;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        // The carry from the add re-enters at bit 7 here, giving the 9th sum bit.
        acc_d = alu_f;
        q_d   = {alu_co, q_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          product_d = {alu_f, alu_co, q_q[7:1]};
          state_d   = DONE;
        end else begin
          state_d = ADD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign alu_own = (state_q == ADD) || (state_q == SHIFT);
  assign product = product_q;

endmodule

// File: tb/tb_alu8_mul_seq.sv
// Testbench for alu8_mul_seq with a behavioural alu8 (ADD and SHR only) and a
// scoreboard of expected products checked whenever done is presented.
module tb_alu8_mul_seq;

  localparam logic [6:0] OP_ADD = 7'b0001001;
  localparam logic [6:0] OP_SHR = 7'b0100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  a_in, b_in;
  logic        busy, done, alu_own;
  logic [15:0] product;
  logic [7:0]  alu_a, alu_b, alu_f;
  logic        alu_ci, alu_co;
  logic [6:0]  alu_op;

  int vectorCount = 0;
  int missCount   = 0;
  bit monitorOn   = 1'b0;
  logic [15:0] sb[$];

  alu8_mul_seq dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product), .alu_own(alu_own),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_op(alu_op),
    .alu_f(alu_f), .alu_co(alu_co)
  );

  always #5 clk = ~clk;

  // Stand-in for alu8: only the two operations the sequencer issues.
  always_comb begin
    logic [8:0] sum;
    sum    = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_ci};
    alu_f  = '0;
    alu_co = 1'b0;
    if (alu_op == OP_ADD) begin
      alu_f  = sum[7:0];
      alu_co = sum[8];
    end else if (alu_op == OP_SHR) begin
      alu_f  = {alu_ci, alu_a[7:1]};
      alu_co = alu_a[0];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] exp, input bit holdStart);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (!holdStart) start = 1'b0;
  endtask

  task automatic waitDone(input int expCycles, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    checkOutput(name, n, expCycles);
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, "_busy"},    busy,    0);
    checkOutput({name, "_done"},    done,    0);
    checkOutput({name, "_alu_own"}, alu_own, 0);
    checkOutput({name, "_product"}, product, 0);
  endtask

  always @(negedge clk) begin
    if (monitorOn && !reset) begin
      if (!alu_own)
        checkOutput("alu_idle_zero", {alu_a, alu_b, alu_ci, alu_op}, 0);
      if (done) begin
        checkOutput("done_busy", busy, 1);
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          checkOutput("product", product, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    monitorOn = 1'b1;
    checkIdle("reset");
    reset = 1'b0;

    // T1: 13 * 11, done exactly 17 cycles after acceptance
    applyStimulus(8'h0D, 8'h0B, 16'h008F, 1'b0);
    waitDone(17, "t1_latency");

    // T2: carry path, product must persist after done
    applyStimulus(8'hFF, 8'hFF, 16'hFE01, 1'b0);
    waitDone(17, "t2_latency");
    @(negedge clk);
    checkOutput("t2_hold", product, 16'hFE01);
    checkOutput("t2_idle_busy", busy, 0);

    // T3: zero operands on either side
    applyStimulus(8'h00, 8'hA5, 16'h0000, 1'b0);
    waitDone(17, "t3a_latency");
    applyStimulus(8'h5A, 8'h00, 16'h0000, 1'b0);
    waitDone(17, "t3b_latency");

    // T4: second start while busy is ignored
    applyStimulus(8'h21, 8'h07, 16'h00E7, 1'b0);
    repeat (4) @(negedge clk);
    a_in  = 8'h99;
    b_in  = 8'h99;
    start = 1'b1;
    checkOutput("t4_busy", busy, 1);
    @(negedge clk);
    start = 1'b0;
    waitDone(12, "t4_latency");

    // T5: reset mid-operation aborts, then a fresh op completes
    applyStimulus(8'h33, 8'h44, 16'h0D8C, 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    checkIdle("t5_abort");
    reset = 1'b0;
    applyStimulus(8'h0F, 8'h11, 16'h00FF, 1'b0);
    waitDone(17, "t5_latency");

    // T6: start held high re-triggers after one IDLE cycle
    applyStimulus(8'h12, 8'h34, 16'h03A8, 1'b1);
    @(negedge clk);
    a_in = 8'h56;
    b_in = 8'h78;
    sb.push_back(16'h2850);
    waitDone(16, "t6a_latency");
    @(negedge clk);
    checkOutput("t6_gap_busy", busy, 0);
    checkOutput("t6_gap_product", product, 16'h03A8);
    @(negedge clk);
    checkOutput("t6_retrigger", busy, 1);
    start = 1'b0;
    waitDone(16, "t6b_latency");

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
